// File: rtl/instr_mem_mux.sv
// Fetch-stage helper: 32-bit 2:1 PC selector plus a word-organised instruction
// memory with a combinational byte-addressed read and a synchronous load port.
module instr_mem_mux #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cs,
  output logic [31:0] out,
  input  logic [31:0] A,
  output logic [31:0] RD,
  input  logic        we,
  input  logic [31:0] WA,
  input  logic [31:0] WD
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 32;

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             rd_in_range;
  logic             wr_in_range;
  logic             load_en;

  // PC offset/jump selection, no clock involvement
  always_comb begin
    out = cs ? in2 : in1;
  end

  // Byte address to word index; any bit above the index range means out of range
  always_comb begin
    rd_idx      = A[AW+1:2];
    wr_idx      = WA[AW+1:2];
    rd_in_range = ((A >> (AW + 2)) == '0);
    wr_in_range = ((WA >> (AW + 2)) == '0);
    load_en     = we && wr_in_range && reset_n;
  end

  // Unloaded or out-of-range locations read as the NOP encoding (all zeros)
  always_comb begin
    RD = '0;
    if (rd_in_range && valid_q[rd_idx]) begin
      RD = data_q[rd_idx];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_en) begin
      valid_d[wr_idx] = 1'b1;
      data_d[wr_idx]  = WD;
    end
  end

  // Only the valid vector is reset; stale data is masked until reloaded
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_instr_mem_mux.sv
// Randomised and directed bench for instr_mem_mux against a word-array model.
module tb_instr_mem_mux;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clock;
  logic        reset_n;
  logic [31:0] in1, in2, out;
  logic        cs;
  logic [31:0] A, RD, WA, WD;
  logic        we;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_data  [DEPTH];
  bit          m_valid [DEPTH];

  instr_mem_mux #(.DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .in1    (in1),
    .in2    (in2),
    .cs     (cs),
    .out    (out),
    .A      (A),
    .RD     (RD),
    .we     (we),
    .WA     (WA),
    .WD     (WD)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int unsigned w;
    if (a >= 32'(BYTES)) return 32'd0;
    w = a / 4;
    return m_valid[w] ? m_data[w] : 32'd0;
  endfunction

  function automatic logic [31:0] model_sel(input logic c, input logic [31:0] x1, input logic [31:0] x2);
    return (c == 1'b1) ? x2 : x1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
  endtask

  // One clock edge; model applies the load seen at that edge, then settle 1 ns
  task automatic cycle();
    @(posedge clock);
    if (we && reset_n && (WA < 32'(BYTES))) begin
      m_data[WA / 4]  = WD;
      m_valid[WA / 4] = 1'b1;
    end
    #1;
  endtask

  task automatic load(input logic [31:0] wa, input logic [31:0] wd);
    we = 1'b1; WA = wa; WD = wd;
    cycle();
    we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    A = a;
    #1;
    check(tag, RD, exp);
    check({tag, "_model"}, RD, model_rd(a));
  endtask

  initial begin
    logic [31:0] r;
    model_clear();
    reset_n = 1'b1; cs = 1'b0; in1 = '0; in2 = '0;
    A = '0; we = 1'b0; WA = '0; WD = '0;

    // Reset with no clock edge involved
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_clear();
    read_chk("rst_a0", 32'd0, 32'd0);
    read_chk("rst_a4", 32'd4, 32'd0);
    read_chk("rst_a252", 32'd252, 32'd0);

    // Selector, toggling cs every 1 ns
    in1 = 32'd4; in2 = 32'h0000_0010;
    cs = 1'b0; #1 check("sel_cs0", out, 32'd4);
    cs = 1'b1; #1 check("sel_cs1", out, 32'h10);
    for (int i = 0; i < 6; i++) begin
      cs = ~cs;
      #1 check("sel_toggle", out, cs ? 32'h10 : 32'd4);
    end

    // Asynchronous clear mid-cycle
    @(negedge clock);
    load(32'd0, 32'h1357_9BDF);
    read_chk("pre_clr", 32'd0, 32'h1357_9BDF);
    reset_n = 1'b0;
    model_clear();
    #1 check("async_clr", RD, 32'd0);
    reset_n = 1'b1;
    #1;

    // Load and fetch
    load(32'd0, 32'h2008_0005);
    load(32'd4, 32'h0109_5020);
    load(32'd8, 32'h0800_0000);
    read_chk("fetch0", 32'd0, 32'h2008_0005);
    read_chk("fetch4", 32'd4, 32'h0109_5020);
    read_chk("fetch8", 32'd8, 32'h0800_0000);
    read_chk("unalign5", 32'd5, 32'h0109_5020);
    read_chk("unloaded12", 32'd12, 32'd0);

    // Boundaries
    load(32'd252, 32'hDEAD_BEEF);
    read_chk("top_word", 32'd252, 32'hDEAD_BEEF);
    load(32'd256, 32'h1234_5678);
    read_chk("oor_256", 32'd256, 32'd0);
    read_chk("no_wrap", 32'd0, 32'h2008_0005);
    read_chk("oor_max", 32'hFFFF_FFFC, 32'd0);

    // Same-cycle load and read
    A = 32'd16; we = 1'b1; WA = 32'd16; WD = 32'hAAAA_5555;
    #1 check("same_pre", RD, 32'd0);
    cycle();
    check("same_post", RD, 32'hAAAA_5555);
    WD = 32'h5555_AAAA;
    cycle();
    check("same_reload", RD, 32'h5555_AAAA);
    we = 1'b0;

    // Load attempted during reset
    reset_n = 1'b0;
    model_clear();
    we = 1'b1; WA = 32'd20; WD = 32'h1;
    cycle();
    we = 1'b0;
    reset_n = 1'b1;
    read_chk("rst_load_drop", 32'd20, 32'd0);
    load(32'd20, 32'h1);
    read_chk("post_rst_load", 32'd20, 32'h1);

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      cs = 1'($urandom); in1 = $urandom; in2 = $urandom;
      #1 check("rnd_sel", out, model_sel(cs, in1, in2));
      r = $urandom;
      A = (r[3:0] == 4'd0) ? $urandom : $urandom_range(0, BYTES - 1);
      #1 check("rnd_rd", RD, model_rd(A));
      if ($urandom_range(0, 49) == 0) begin
        reset_n = 1'b0;
        model_clear();
        #1 check("rnd_rst", RD, 32'd0);
        reset_n = 1'b1;
      end
      we = 1'($urandom);
      WA = ($urandom_range(0, 7) == 0) ? $urandom_range(BYTES, 2 * BYTES) : $urandom_range(0, BYTES - 1);
      WD = $urandom;
      cycle();
      we = 1'b0;
      check("rnd_rd_post", RD, model_rd(A));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
